// File: rtl/shreg_pipe.sv
// ============================================================================
// Module      : shreg_pipe
// Description : Parametrised multi-bit shift-register delay line with valid
//               tracking, parallel load, bidirectional shift, selectable tap
//               and occupancy count. Optional rotate feedback is enabled by
//               defining the macro SHREG_ROTATE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shreg_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    parameter int TAP_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                   c,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   clr,
    input  logic                   load,
    input  logic                   dir,
    input  logic [WIDTH-1:0]       din,
    input  logic                   din_vld,
    input  logic [DEPTH*WIDTH-1:0] pdin,
    input  logic                   rot,
    input  logic [TAP_W-1:0]       tap_sel,
    output logic [WIDTH-1:0]       sout,
    output logic                   sout_vld,
    output logic [WIDTH-1:0]       tap_out,
    output logic [DEPTH*WIDTH-1:0] pdout,
    output logic [CNT_W-1:0]       fill_cnt
);

    logic [DEPTH-1:0][WIDTH-1:0] r_stg;
    logic [DEPTH-1:0]            r_vld;

    logic [WIDTH-1:0] w_out_d;
    logic             w_out_v;
    logic [WIDTH-1:0] w_in_d;
    logic             w_in_v;
    logic [WIDTH-1:0] w_tap;
    logic [CNT_W-1:0] w_cnt;

    // The outgoing end follows the current direction, not the one in flight.
    assign w_out_d = dir ? r_stg[0] : r_stg[DEPTH-1];
    assign w_out_v = dir ? r_vld[0] : r_vld[DEPTH-1];

`ifdef SHREG_ROTATE_EN
    assign w_in_d = rot ? w_out_d : din;
    assign w_in_v = rot ? w_out_v : din_vld;
`else
    logic w_unused_rot;
    assign w_unused_rot = rot;
    assign w_in_d       = din;
    assign w_in_v       = din_vld;
`endif

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            r_stg <= '0;
            r_vld <= '0;
        end else if (clr) begin
            r_stg <= '0;
            r_vld <= '0;
        end else if (load) begin
            r_stg <= pdin;
            r_vld <= '1;
        end else if (en) begin
            if (!dir) begin
                r_stg <= {r_stg[DEPTH-2:0], w_in_d};
                r_vld <= {r_vld[DEPTH-2:0], w_in_v};
            end else begin
                r_stg <= {w_in_d, r_stg[DEPTH-1:1]};
                r_vld <= {w_in_v, r_vld[DEPTH-1:1]};
            end
        end
    end

    // Out-of-range selects (non-power-of-2 depth) fall through to zero.
    always_comb begin
        w_tap = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (tap_sel == TAP_W'(i)) begin
                w_tap = r_stg[i];
            end
        end
    end

    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_cnt = w_cnt + CNT_W'(r_vld[i]);
        end
    end

    assign sout     = w_out_d;
    assign sout_vld = w_out_v;
    assign tap_out  = w_tap;
    assign pdout    = r_stg;
    assign fill_cnt = w_cnt;

endmodule

`default_nettype wire

// File: tb/tb_shreg_pipe.sv
// Directed self-checking bench for shreg_pipe (default build, rotate disabled)
// covering a DEPTH=3 and a DEPTH=4 instance.
`default_nettype none

module tb_shreg_pipe;

    logic        c;
    logic        rst_n;

    logic        en, clr, load, dir, din_vld, rot;
    logic [7:0]  din;
    logic [23:0] pdin;
    logic [1:0]  tap_sel;
    logic [7:0]  sout, tap_out;
    logic        sout_vld;
    logic [23:0] pdout;
    logic [1:0]  fill_cnt;

    logic        b_en, b_clr, b_load, b_dir, b_din_vld, b_rot;
    logic [3:0]  b_din;
    logic [15:0] b_pdin;
    logic [1:0]  b_tap_sel;
    logic [3:0]  b_sout, b_tap_out;
    logic        b_sout_vld;
    logic [15:0] b_pdout;
    logic [2:0]  b_fill_cnt;

    int checks   = 0;
    int failures = 0;

    shreg_pipe #(.WIDTH(8), .DEPTH(3)) u0 (
        .c(c), .rst_n(rst_n), .en(en), .clr(clr), .load(load), .dir(dir),
        .din(din), .din_vld(din_vld), .pdin(pdin), .rot(rot), .tap_sel(tap_sel),
        .sout(sout), .sout_vld(sout_vld), .tap_out(tap_out), .pdout(pdout),
        .fill_cnt(fill_cnt)
    );

    shreg_pipe #(.WIDTH(4), .DEPTH(4)) u1 (
        .c(c), .rst_n(rst_n), .en(b_en), .clr(b_clr), .load(b_load), .dir(b_dir),
        .din(b_din), .din_vld(b_din_vld), .pdin(b_pdin), .rot(b_rot),
        .tap_sel(b_tap_sel), .sout(b_sout), .sout_vld(b_sout_vld),
        .tap_out(b_tap_out), .pdout(b_pdout), .fill_cnt(b_fill_cnt)
    );

    initial begin
        c = 1'b0;
        forever #5 c = ~c;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge c);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        en = 0; clr = 0; load = 0; dir = 0; din_vld = 0; rot = 0;
        din = '0; pdin = '0; tap_sel = '0;
        b_en = 0; b_clr = 0; b_load = 0; b_dir = 0; b_din_vld = 0; b_rot = 0;
        b_din = '0; b_pdin = '0; b_tap_sel = '0;

        #12;
        chk("rst_sout",     32'(sout),     32'h0);
        chk("rst_sout_vld", 32'(sout_vld), 32'h0);
        chk("rst_pdout",    32'(pdout),    32'h0);
        chk("rst_fill",     32'(fill_cnt), 32'h0);
        rst_n = 1'b1;

        // Fill the DEPTH=3 pipe left to right
        en = 1; dir = 0; din_vld = 1;
        din = 8'h11; step();
        chk("fill1", 32'(fill_cnt), 32'd1);
        din = 8'h22; step();
        chk("fill2", 32'(fill_cnt), 32'd2);
        din = 8'h33; step();
        chk("fill3",      32'(fill_cnt), 32'd3);
        chk("t1_sout",    32'(sout),     32'h11);
        chk("t1_soutvld", 32'(sout_vld), 32'h1);
        chk("t1_pdout",   32'(pdout),    32'h112233);
        tap_sel = 2'd1; #1;
        chk("t1_tap1",    32'(tap_out),  32'h22);

        // Hold with en low while din toggles
        en = 0;
        for (int k = 0; k < 5; k++) begin
            din = (k % 2 == 0) ? 8'hFF : 8'h00;
            din_vld = ~din_vld;
            step();
        end
        chk("hold_pdout", 32'(pdout),    32'h112233);
        chk("hold_fill",  32'(fill_cnt), 32'd3);

        // Asynchronous reset between edges
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pdout",   32'(pdout),    32'h0);
        chk("arst_fill",    32'(fill_cnt), 32'h0);
        chk("arst_sout",    32'(sout),     32'h0);
        chk("arst_soutvld", 32'(sout_vld), 32'h0);
        chk("arst_tap",     32'(tap_out),  32'h0);
        rst_n = 1'b1;

        // Parallel load, taps, reverse shift with invalid input
        load = 1; pdin = 24'h332211; din_vld = 0;
        step();
        load = 0;
        chk("ld_pdout", 32'(pdout),    32'h332211);
        chk("ld_fill",  32'(fill_cnt), 32'd3);
        tap_sel = 2'd1; #1;
        chk("ld_tap1",  32'(tap_out),  32'h22);
        tap_sel = 2'd2; #1;
        chk("ld_tap2",  32'(tap_out),  32'h33);
        tap_sel = 2'd3; #1;
        chk("ld_tap3",  32'(tap_out),  32'h00);
        dir = 1; en = 1; din = 8'hAA; din_vld = 0; #1;
        chk("rev_pre_sout", 32'(sout), 32'h11);
        step();
        en = 0;
        chk("rev_pdout",   32'(pdout),    32'hAA3322);
        chk("rev_sout",    32'(sout),     32'h22);
        chk("rev_soutvld", 32'(sout_vld), 32'h1);
        chk("rev_fill",    32'(fill_cnt), 32'd2);
        dir = 0; #1;
        chk("dir0_sout",    32'(sout),     32'hAA);
        chk("dir0_soutvld", 32'(sout_vld), 32'h0);

        // Clear beats load and shift
        load = 1; pdin = 24'h332211; step();
        clr = 1; load = 1; en = 1; din = 8'h5A; din_vld = 1;
        step();
        clr = 0; load = 0; en = 0;
        chk("clr_pdout",   32'(pdout),    32'h0);
        chk("clr_fill",    32'(fill_cnt), 32'h0);
        chk("clr_soutvld", 32'(sout_vld), 32'h0);

        // Rotate request ignored in the default build
        load = 1; pdin = 24'h332211; step();
        load = 0; dir = 0; rot = 1; en = 1; din = 8'h00; din_vld = 0;
        step(); step(); step();
        en = 0; rot = 0;
        chk("norot_pdout", 32'(pdout),    32'h0);
        chk("norot_fill",  32'(fill_cnt), 32'h0);

        // DEPTH=4 latency, with a stalled cycle that must not count
        b_en = 1; b_dir = 0; b_din_vld = 1;
        b_din = 4'h1; step();
        b_din = 4'h2; step();
        b_en = 0; b_din = 4'hF; step();
        chk("d4_stall_fill", 32'(b_fill_cnt), 32'd2);
        b_en = 1; b_din = 4'h3; step();
        chk("d4_3_soutvld", 32'(b_sout_vld), 32'h0);
        b_din = 4'h4; step();
        b_en = 0;
        chk("d4_sout",    32'(b_sout),     32'h1);
        chk("d4_soutvld", 32'(b_sout_vld), 32'h1);
        chk("d4_pdout",   32'(b_pdout),    32'h1234);
        chk("d4_fill",    32'(b_fill_cnt), 32'd4);
        b_tap_sel = 2'd3; #1;
        chk("d4_tap3",    32'(b_tap_out),  32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
